montgomery_square_arbiter: RTL and testbench

- Shares one Montgomery squarer stream core between two requesters (two encryption lanes), one job at a time.
- Grants a job round-robin, forwards the winner's operand blocks into the squarer, and counts the squarer's output passes.
- Routes every output block back to the job's owner, with last-block and final-pass markers.
- Sits between the lane controllers and the squarer core; the N/k constant feeders connect directly to the core.

---
 rtl/montgomery_square_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_montgomery_square_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_square_arbiter.sv
// Round-robin sharing of one Montgomery squarer stream core between two encryption lanes.
// Optional MONT_ARB_WATCHDOG_EN adds a RUN-state stall watchdog (wdog_err_out, sq_rst_out).

module montgomery_square_arbiter #(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned BITS_IN_NUM   = 2048,
    parameter int unsigned PASSES        = 10,
    parameter int unsigned WDOG_CYCLES   = 65536
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [1:0]                 req_valid_in,
    input  logic [2*REGISTER_SIZE-1:0] req_block_in,
    output logic [1:0]                 req_ready_out,
    output logic [1:0]                 grant_out,
    output logic [REGISTER_SIZE-1:0]   sq_block_out,
    output logic                       sq_valid_out,
    input  logic                       sq_ready_in,
    input  logic [REGISTER_SIZE-1:0]   sq_block_in,
    input  logic                       sq_valid_in,
    output logic [REGISTER_SIZE-1:0]   resp_block_out,
    output logic [1:0]                 resp_valid_out,
    output logic                       resp_last_out,
    output logic                       resp_final_out,
    output logic                       busy_out
`ifdef MONT_ARB_WATCHDOG_EN
    ,
    output logic                       wdog_err_out,
    output logic                       sq_rst_out
`endif
);

    localparam int unsigned IN_BLOCKS = 2 * BITS_IN_NUM / REGISTER_SIZE;
    localparam int unsigned CTR_W     = $clog2(IN_BLOCKS);
    localparam int unsigned PASS_W    = $clog2(PASSES) + 1;
    localparam logic [CTR_W-1:0]  LAST_BLK  = CTR_W'(IN_BLOCKS - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);
`ifdef MONT_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state, state_nxt;
    logic [1:0]        grant, grant_nxt;
    logic              last_grant, last_grant_nxt;
    logic [CTR_W-1:0]  in_ctr, in_ctr_nxt;
    logic [CTR_W-1:0]  out_ctr, out_ctr_nxt;
    logic [PASS_W-1:0] pass_ctr, pass_ctr_nxt;
    logic              win;
    logic              gidx;
`ifdef MONT_ARB_WATCHDOG_EN
    logic [WD_W-1:0]   wdog_ctr, wdog_ctr_nxt;
    logic              wdog_err, wdog_err_nxt;
    logic              sq_rst, sq_rst_nxt;
`endif

    assign gidx      = grant[1];
    assign grant_out = grant;
    assign busy_out  = (state != IDLE);
`ifdef MONT_ARB_WATCHDOG_EN
    assign wdog_err_out = wdog_err;
    assign sq_rst_out   = sq_rst;
`endif

    // State and counter registers; an in-flight job is dropped on reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 1'b1;
            in_ctr     <= '0;
            out_ctr    <= '0;
            pass_ctr   <= '0;
`ifdef MONT_ARB_WATCHDOG_EN
            wdog_ctr   <= '0;
            wdog_err   <= 1'b0;
            sq_rst     <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            in_ctr     <= in_ctr_nxt;
            out_ctr    <= out_ctr_nxt;
            pass_ctr   <= pass_ctr_nxt;
`ifdef MONT_ARB_WATCHDOG_EN
            wdog_ctr   <= wdog_ctr_nxt;
            wdog_err   <= wdog_err_nxt;
            sq_rst     <= sq_rst_nxt;
`endif
        end
    end

    // Arbitration, operand forwarding and response routing.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        in_ctr_nxt     = in_ctr;
        out_ctr_nxt    = out_ctr;
        pass_ctr_nxt   = pass_ctr;
        win            = 1'b0;
        req_ready_out  = '0;
        sq_valid_out   = 1'b0;
        sq_block_out   = '0;
        resp_valid_out = '0;
        resp_block_out = '0;
        resp_last_out  = 1'b0;
        resp_final_out = 1'b0;
`ifdef MONT_ARB_WATCHDOG_EN
        wdog_ctr_nxt   = '0;
        wdog_err_nxt   = wdog_err;
        sq_rst_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sq_ready_in && (|req_valid_in)) begin
                    // On contention the requester not served last time wins.
                    win       = (req_valid_in == 2'b11) ? ~last_grant : req_valid_in[1];
                    grant_nxt = win ? 2'b10 : 2'b01;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                req_ready_out = grant;
                sq_valid_out  = req_valid_in[gidx];
                sq_block_out  = gidx ? req_block_in[2*REGISTER_SIZE-1:REGISTER_SIZE]
                                     : req_block_in[REGISTER_SIZE-1:0];
                if (req_valid_in[gidx]) begin
                    if (in_ctr == LAST_BLK) begin
                        in_ctr_nxt = '0;
                        state_nxt  = RUN;
                    end else begin
                        in_ctr_nxt = in_ctr + CTR_W'(1);
                    end
                end
            end
            RUN: begin
                if (sq_valid_in) begin
                    resp_valid_out = grant;
                    resp_block_out = sq_block_in;
                    if (out_ctr == LAST_BLK) begin
                        resp_last_out = 1'b1;
                        out_ctr_nxt   = '0;
                        if (pass_ctr == LAST_PASS) begin
                            resp_final_out = 1'b1;
                            pass_ctr_nxt   = '0;
                            last_grant_nxt = gidx;
                            grant_nxt      = '0;
                            state_nxt      = IDLE;
                        end else begin
                            pass_ctr_nxt = pass_ctr + PASS_W'(1);
                        end
                    end else begin
                        out_ctr_nxt = out_ctr + CTR_W'(1);
                    end
                end
`ifdef MONT_ARB_WATCHDOG_EN
                // Silent squarer: abandon the job and kick the core.
                else if (wdog_ctr == WD_LAST) begin
                    wdog_err_nxt   = 1'b1;
                    sq_rst_nxt     = 1'b1;
                    grant_nxt      = '0;
                    last_grant_nxt = gidx;
                    out_ctr_nxt    = '0;
                    pass_ctr_nxt   = '0;
                    state_nxt      = IDLE;
                end else begin
                    wdog_ctr_nxt = wdog_ctr + WD_W'(1);
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_montgomery_square_arbiter.sv
// Scoreboard bench for montgomery_square_arbiter: random requesters and a behavioural squarer model.

module tb_montgomery_square_arbiter;

    localparam int unsigned RS = 32;
    localparam int NB = 128;
    localparam int NP = 10;

    typedef struct packed {
        logic [1:0]    owner;
        logic [RS-1:0] data;
        logic          last;
        logic          fin;
    } resp_t;

    logic            clk, rst;
    logic            rv [2];
    logic [RS-1:0]   rb [2];
    logic [1:0]      req_valid;
    logic [2*RS-1:0] req_block;
    logic [1:0]      req_ready, grant, resp_v;
    logic [RS-1:0]   sq_blk_o, sq_blk_i, resp_blk;
    logic            sq_vo, sq_vi, sq_ready;
    logic            resp_last, resp_final, busy;
`ifdef MONT_ARB_WATCHDOG_EN
    logic            wdog_err, sq_rst;
`endif

    assign req_valid = {rv[1], rv[0]};
    assign req_block = {rb[1], rb[0]};

    montgomery_square_arbiter #(.WDOG_CYCLES(100)) dut (
        .clk_in(clk), .rst_in(rst),
        .req_valid_in(req_valid), .req_block_in(req_block), .req_ready_out(req_ready),
        .grant_out(grant),
        .sq_block_out(sq_blk_o), .sq_valid_out(sq_vo), .sq_ready_in(sq_ready),
        .sq_block_in(sq_blk_i), .sq_valid_in(sq_vi),
        .resp_block_out(resp_blk), .resp_valid_out(resp_v),
        .resp_last_out(resp_last), .resp_final_out(resp_final), .busy_out(busy)
`ifdef MONT_ARB_WATCHDOG_EN
        , .wdog_err_out(wdog_err), .sq_rst_out(sq_rst)
`endif
    );

    always #5 clk = ~clk;

    logic [RS-1:0] exp_fwd [$];
    resp_t         exp_resp [$];
    int            job_owner [$];
    int            n_checks, n_pass;
    logic [31:0]   salt;
    bit            abort, sq_flush, chk_idle_next;
    bit            req_done [2];
    int            stall_at, loaded, emitted, owner;
    bit            emitting;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic note_fail(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: actual=0x%0h required=nothing", name, act);
    endtask

    function automatic logic [RS-1:0] blk(input int r, input int j, input int idx);
        return {4'(r + 1), 4'(j), 8'(idx), salt[15:0]};
    endfunction

    // Reference arbitration: contention alternates, lone requester always wins.
    task automatic plan_jobs(input int n0, input int n1, input int last);
        int p [2];
        int jn [2];
        int w;
        p[0] = n0; p[1] = n1; jn[0] = 0; jn[1] = 0;
        while (p[0] + p[1] > 0) begin
            if (p[0] > 0 && p[1] > 0) w = 1 - last;
            else w = (p[0] > 0) ? 0 : 1;
            job_owner.push_back(w);
            for (int i = 0; i < NB; i++) exp_fwd.push_back(blk(w, jn[w], i));
            jn[w]++; p[w]--; last = w;
        end
    endtask

    // Lane controller: streams jobs, holding valid for the first block of each job.
    task automatic drive_req(input int r, input int jobs, input bit rnd_gaps, input int gap_at);
        int j = 0, idx = 0, gap_left = 0;
        bit gap_used = 0, fire;
        while (j < jobs && !abort) begin
            if (!gap_used && idx == gap_at) begin gap_left = 5; gap_used = 1; end
            if (gap_left > 0) begin
                rv[r] = 1'b0; gap_left--;
            end else if (rnd_gaps && idx != 0 && $urandom_range(7) == 0) begin
                rv[r] = 1'b0;
            end else begin
                rv[r] = 1'b1; rb[r] = blk(r, j, idx);
            end
            #1;
            fire = rv[r] && req_ready[r];
            @(negedge clk);
            if (fire) begin
                idx++;
                if (idx == NB) begin idx = 0; j++; end
            end
        end
        rv[r] = 1'b0;
        req_done[r] = 1'b1;
    endtask

    // Squarer model: absorbs 128 blocks, then emits 10 passes; noise pulses while not emitting.
    initial begin : squarer
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst || sq_flush) begin
                loaded = 0; emitted = 0; emitting = 0; sq_vi = 1'b0;
            end else if (emitting) begin
                if (emitted < stall_at && $urandom_range(3) != 0) begin
                    e.owner = (owner == 1) ? 2'b10 : 2'b01;
                    e.data  = $urandom;
                    e.last  = (emitted % NB == NB - 1);
                    e.fin   = (emitted == NB * NP - 1);
                    sq_vi = 1'b1; sq_blk_i = e.data;
                    exp_resp.push_back(e);
                    emitted++;
                    if (emitted == NB * NP) emitting = 0;
                end else begin
                    sq_vi = 1'b0;
                end
            end else begin
                sq_vi = ($urandom_range(3) == 0); sq_blk_i = $urandom;
                #1;
                if (sq_vo) begin
                    if (loaded == 0) owner = (job_owner.size() > 0) ? job_owner.pop_front() : 0;
                    loaded++;
                    if (loaded == NB) begin loaded = 0; emitted = 0; emitting = 1; end
                end
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT forwards or responds.
    initial begin : monitor
        resp_t me;
        forever begin
            @(negedge clk);
            #2;
            if (chk_idle_next) begin
                chk("busy_after_final", busy, 0);
                chk("grant_after_final", grant, 0);
                chk_idle_next = 0;
            end
            if (sq_vo) begin
                if (exp_fwd.size() == 0) note_fail("fwd_unexpected", sq_blk_o);
                else chk("fwd_block", sq_blk_o, exp_fwd.pop_front());
            end
            if (resp_v != 2'b00) begin
                if (exp_resp.size() == 0) note_fail("resp_unexpected", {resp_v, resp_blk});
                else begin
                    me = exp_resp.pop_front();
                    chk("resp_owner", resp_v, me.owner);
                    chk("resp_block", resp_blk, me.data);
                    chk("resp_last", resp_last, me.last);
                    chk("resp_final", resp_final, me.fin);
                    if (me.fin) chk_idle_next = 1;
                end
            end else if (resp_last || resp_final) begin
                note_fail("marker_without_valid", {resp_last, resp_final});
            end
        end
    end

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        while (!(req_done[0] && req_done[1] && exp_fwd.size() == 0 && exp_resp.size() == 0 &&
                 job_owner.size() == 0 && !emitting && loaded == 0) && c < budget) begin
            @(negedge clk); #3; c++;
        end
        chk(name, c < budget, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_sq_valid"}, sq_vo, 0);
        chk({tag, "_sq_block"}, sq_blk_o, 0);
        chk({tag, "_resp_valid"}, resp_v, 0);
        chk({tag, "_resp_markers"}, {resp_last, resp_final}, 0);
    endtask

    initial begin : main
        int c;
        clk = 0; rst = 1; rv[0] = 0; rv[1] = 0; rb[0] = '0; rb[1] = '0;
        sq_vi = 0; sq_blk_i = '0; sq_ready = 1; abort = 0; sq_flush = 0; chk_idle_next = 0;
        stall_at = 1 << 30; req_done[0] = 1; req_done[1] = 1;
        n_checks = 0; n_pass = 0; loaded = 0; emitted = 0; emitting = 0; owner = 0;
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk);

        // Lone requester 0 with a 5-cycle valid gap at block 40.
        salt = $urandom; plan_jobs(1, 0, 1); req_done[0] = 0;
        fork drive_req(0, 1, 0, 40); join_none
        @(negedge clk); #1;
        chk("A_grant_next_cycle", grant, 2'b01);
        chk("A_busy", busy, 1);
        wait_done("A_job_complete", 4000);

        // Both requesters from reset, two jobs each with random gaps.
        rst = 1; @(negedge clk); rst = 0; @(negedge clk);
        salt = $urandom; plan_jobs(2, 2, 1); req_done[0] = 0; req_done[1] = 0;
        fork drive_req(0, 2, 1, -1); drive_req(1, 2, 1, -1); join_none
        @(negedge clk); #1;
        chk("B_first_grant", grant, 2'b01);
        wait_done("B_jobs_complete", 12000);

        // Reset during pass 4, then requester 1 alone.
        salt = $urandom; plan_jobs(1, 0, 1); req_done[0] = 0;
        fork drive_req(0, 1, 0, -1); join_none
        c = 0;
        while (!(emitting && emitted >= 4 * NB + 10) && c < 3000) begin @(negedge clk); c++; end
        chk("C_reached_pass4", c < 3000, 1);
        #3; rst = 1; abort = 1;
        exp_fwd.delete(); exp_resp.delete(); job_owner.delete();
        #1 chk_all_zero("C_async_reset");
        repeat (3) @(negedge clk);
        rst = 0; abort = 0;
        @(negedge clk);
        salt = $urandom; plan_jobs(0, 1, 1); req_done[1] = 0;
        fork drive_req(1, 1, 1, -1); join_none
        @(negedge clk); #1;
        chk("C_req1_grant", grant, 2'b10);
        wait_done("C_job_complete", 4000);

`ifdef MONT_ARB_WATCHDOG_EN
        // Squarer goes silent after pass 2; watchdog must recover.
        salt = $urandom; plan_jobs(1, 0, 1); req_done[0] = 0; stall_at = 3 * NB;
        fork drive_req(0, 1, 1, -1); join_none
        c = 0;
        while (!wdog_err && c < 3000) begin @(negedge clk); #1; c++; end
        chk("D_wdog_fired", c < 3000, 1);
        chk("D_sq_rst_pulse", sq_rst, 1);
        chk("D_grant_cleared", grant, 0);
        chk("D_idle", busy, 0);
        exp_resp.delete(); sq_flush = 1; stall_at = 1 << 30;
        @(negedge clk); #1;
        chk("D_sq_rst_one_cycle", sq_rst, 0);
        chk("D_wdog_sticky", wdog_err, 1);
        sq_flush = 0;
        @(negedge clk);
        salt = $urandom; plan_jobs(0, 1, 0); req_done[1] = 0;
        fork drive_req(1, 1, 1, -1); join_none
        @(negedge clk); #1;
        chk("D_regrant", grant, 2'b10);
        wait_done("D_job_complete", 4000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
